pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register, successor to the fixed IF/ID latch. Used for IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Carries a DATA_W payload with valid/ready handshake, plus start gating, stall, flush and an optional 2-entry skid buffer.
//  Sits between two pipeline stages; the hazard unit drives stall_i/flush_i.
// PARAMETERS
//  DATA_W     64  payload width in bits (e.g. PC+instruction)
//  SKID       1   1: main+skid regs, in_ready_o registered; 0: single reg, in_ready_o combinational
//  FLUSH_ZERO 1   1: flush also zeroes data regs; 0: flush clears valid only
// PORTS
//  clk          in   1       clock, rising edge
//  rst_i        in   1       asynchronous, active-low reset
//  start_i      in   1       core run enable; 0 freezes the stage
//  stall_i      in   1       hold stage contents
//  flush_i      in   1       discard stage contents
//  in_valid_i   in   1       upstream payload valid
//  in_ready_o   out  1       stage can accept
//  in_data_i    in   DATA_W  upstream payload
//  out_valid_o  out  1       downstream payload valid
//  out_ready_i  in   1       downstream accepts
//  out_data_o   out  DATA_W  downstream payload
//  start_o      out  1       registered start_i
// BEHAVIOUR
//  Reset (rst_i=0, async): start_o=0, out_valid_o=0, out_data_o=0, skid valid/data=0; in_ready_o=0 while in reset.
//  start_o <= start_i every cycle. Handshakes and registers update only while start_i=1.
//  Priority, highest first: reset > start_i=0 (freeze) > flush_i > stall_i > normal.
//  Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
//  Latency is 1 cycle from in-transfer to out_valid_o. Full throughput is 1/clk. Order is preserved.
//  flush_i=1: next cycle main and skid valid=0; data=0 if FLUSH_ZERO.
//   in_ready_o=0 and out_valid_o=0 during a flush cycle; a same-cycle input is dropped.
//  stall_i=1 (no flush): in_ready_o=0, out_valid_o=0, all regs hold.
//   After release, out_valid_o/out_data_o are restored unchanged.
//  SKID=1: in_ready_o = ~skid_valid (registered).
//   Out-stall with main valid and an input transfer: the input goes to skid.
//   When the out-transfer completes, skid moves to main; main is refilled from skid before in_data_i.
//   Both regs full: in_ready_o=0.
//  SKID=0: in_ready_o = ~out_valid_o | out_ready_i (combinational path from out_ready_i).
//  Simultaneous in- and out-transfer with one entry held: main takes in_data_i, valid stays 1.
//  start_i falling mid-transfer: current state is held, nothing is lost or duplicated; resumes when start_i=1.
//  No payload arithmetic; data is passed bit-exact.
// CONFIGURATION
//  Macro PIPE_PERF_CNT_EN:
//   Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
//    Counters increment on each cycle with start_i & stall_i, and start_i & flush_i, respectively.
//    They saturate at 32'hFFFF_FFFF and reset to 0.
//   Undefined: the ports and counters are absent; the rest of the behaviour is identical.
// STRUCTURE
//  Shared package pipe_pkg: PIPE_CTRL_W, localparams for stage payload widths (IF_ID_W=64, ...), counter width 32.
//  One sub-module, pipe_perf_cnt (saturating counter), instantiated twice only under PIPE_PERF_CNT_EN.
//  Skid logic is inline and selected by a generate on SKID.
// TESTING
//  1 Reset: hold rst_i=0 mid-stream with out_valid_o=1 -> out_valid_o=0, out_data_o=0 immediately (async); start_o=0.
//  2 Streaming: start_i=1, out_ready_i=1, inputs 0x1..0x8 back-to-back
//    -> out_data_o=0x1..0x8 one cycle later each, no bubbles, in_ready_o=1 throughout.
//  3 Back-pressure (SKID=1): out_ready_i=0 after 0xA accepted, offer 0xB
//    -> 0xB accepted into skid, in_ready_o=0 next cycle.
//    Release -> 0xA then 0xB out, no loss or duplication.
//  4 Flush: main=0xA, skid=0xB, flush_i=1 with in_valid_i=1, data 0xC
//    -> next cycle out_valid_o=0, out_data_o=0 (FLUSH_ZERO=1), 0xC dropped.
//  5 Stall vs flush: stall_i=1 two cycles holding 0x5 -> out_valid_o=0, data held; release -> 0x5 out once.
//    stall_i=flush_i=1 -> flush wins.
//  6 Start gating and counters: start_i=0 with in_valid_i=1 -> nothing accepted, start_o=0 next cycle.
//    Under PIPE_PERF_CNT_EN, 3 stall cycles and 1 flush cycle -> stall_cnt_o=3, flush_cnt_o=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   pipe_ctrl_t  : hazard-unit control bundle (start, stall, flush)
//   *_W          : payload widths of the four inter-stage registers
//   cnt_t        : performance counter type, plus a saturating increment helper
package pipe_pkg;

  typedef struct packed {
    logic start;
    logic stall;
    logic flush;
  } pipe_ctrl_t;

  localparam int unsigned PIPE_CTRL_W = $bits(pipe_ctrl_t);

  localparam int unsigned IF_ID_W  = 64;   // PC + instruction
  localparam int unsigned ID_EX_W  = 128;
  localparam int unsigned EX_MEM_W = 96;
  localparam int unsigned MEM_WB_W = 72;

  localparam int unsigned CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  // Holds at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
//   master : drives valid and data, receives ready
//   slave  : receives valid and data, drives ready
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 64
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used by pipe_stage_reg for stall/flush statistics.
// Only elaborated when PIPE_PERF_CNT_EN is defined.
//   clk   : clock, rising edge
//   rst_i : asynchronous active-low reset, clears the count
//   inc_i : count one event this cycle
//   cnt_o : current count, sticks at all-ones
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst_i,
  input  logic inc_i,
  output cnt_t cnt_o
);

  cnt_t cnt_q;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Passes a DATA_W payload bit-exact with 1-cycle latency and full throughput, gated by
// start_i and controlled by the hazard unit through stall_i / flush_i.
// Priority: reset > start_i=0 (freeze) > flush_i > stall_i > normal.
//   clk          : clock, rising edge
//   rst_i        : asynchronous active-low reset
//   start_i      : run enable; 0 freezes all state and handshakes
//   stall_i      : hold contents, no handshakes
//   flush_i      : drop contents (and same-cycle input)
//   in_if        : upstream valid/ready/data (slave)
//   out_if       : downstream valid/ready/data (master)
//   start_o      : start_i delayed by one cycle
//   stall_cnt_o  : cycles with start_i & stall_i   (PIPE_PERF_CNT_EN only)
//   flush_cnt_o  : cycles with start_i & flush_i   (PIPE_PERF_CNT_EN only)
// Parameters: SKID=1 adds a second entry and makes in_ready depend only on state;
// SKID=0 uses one entry with in_ready combinational on out ready. FLUSH_ZERO=1 also clears
// payload registers on flush.
// Define PIPE_PERF_CNT_EN to add the saturating stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = IF_ID_W,
  parameter int unsigned SKID       = 1,
  parameter int unsigned FLUSH_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  output logic             start_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output cnt_t             stall_cnt_o,
  output cnt_t             flush_cnt_o
`endif
);

  pipe_ctrl_t ctrl;
  assign ctrl = '{start: start_i, stall: stall_i, flush: flush_i};

  logic              run;
  logic              in_ready;
  logic              out_valid;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_valid_q;
  logic [DATA_W-1:0] main_data_q;
  logic              start_q;

  // Handshakes are only offered while running normally; this also keeps a frozen or stalled
  // stage from presenting a transfer it will not commit.
  assign run       = ctrl.start & ~ctrl.flush & ~ctrl.stall;
  assign out_valid = run & main_valid_q;
  assign in_xfer   = in_if.valid & in_ready;
  assign out_xfer  = out_valid & out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_data_q;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      start_q <= 1'b0;
    end else begin
      start_q <= ctrl.start;
    end
  end

  assign start_o = start_q;

  if (SKID != 0) begin : g_skid
    logic              skid_valid_q;
    logic [DATA_W-1:0] skid_data_q;

    // rst_i gate keeps ready low during reset even though skid_valid_q is 0 then.
    assign in_ready = rst_i & run & ~skid_valid_q;

    always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
        main_valid_q <= 1'b0;
        main_data_q  <= '0;
        skid_valid_q <= 1'b0;
        skid_data_q  <= '0;
      end else if (ctrl.start) begin
        if (ctrl.flush) begin
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
          if (FLUSH_ZERO != 0) begin
            main_data_q <= '0;
            skid_data_q <= '0;
          end
        end else if (!ctrl.stall) begin
          if (out_xfer) begin
            // Skid is older than anything arriving now, so it refills main first.
            // in_xfer cannot coincide with a full skid since in_ready is low then.
            if (skid_valid_q) begin
              main_data_q  <= skid_data_q;
              skid_valid_q <= 1'b0;
            end else if (in_xfer) begin
              main_data_q <= in_if.data;
            end else begin
              main_valid_q <= 1'b0;
            end
          end else if (in_xfer) begin
            if (main_valid_q) begin
              skid_valid_q <= 1'b1;
              skid_data_q  <= in_if.data;
            end else begin
              main_valid_q <= 1'b1;
              main_data_q  <= in_if.data;
            end
          end
        end
      end
    end
  end else begin : g_no_skid
    assign in_ready = rst_i & run & (~main_valid_q | out_if.ready);

    always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
        main_valid_q <= 1'b0;
        main_data_q  <= '0;
      end else if (ctrl.start) begin
        if (ctrl.flush) begin
          main_valid_q <= 1'b0;
          if (FLUSH_ZERO != 0) begin
            main_data_q <= '0;
          end
        end else if (!ctrl.stall) begin
          if (in_xfer) begin
            main_valid_q <= 1'b1;
            main_data_q  <= in_if.data;
          end else if (out_xfer) begin
            main_valid_q <= 1'b0;
          end
        end
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst_i (rst_i),
    .inc_i (ctrl.start & ctrl.stall),
    .cnt_o (stall_cnt_o)
  );

  pipe_perf_cnt u_flush_cnt (
    .clk   (clk),
    .rst_i (rst_i),
    .inc_i (ctrl.start & ctrl.flush),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (SKID=1, FLUSH_ZERO=1). The reference model is a
// FIFO queue of accepted payloads with capacity 2.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned DW  = 64;
  localparam int unsigned CAP = 2;

  logic clk     = 1'b0;
  logic rst_i   = 1'b0;
  logic start_i = 1'b0;
  logic stall_i = 1'b0;
  logic flush_i = 1'b0;
  logic start_o;

  pipe_stage_reg_if #(.DATA_W(DW)) in_if ();
  pipe_stage_reg_if #(.DATA_W(DW)) out_if ();

`ifdef PIPE_PERF_CNT_EN
  cnt_t        stall_cnt;
  cnt_t        flush_cnt;
  int unsigned n_stall = 0;
  int unsigned n_flush = 0;
`endif

  pipe_stage_reg #(
    .DATA_W     (DW),
    .SKID       (1),
    .FLUSH_ZERO (1)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .in_if       (in_if),
    .out_if      (out_if),
    .start_o     (start_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mq[$];
  logic          exp_start_o = 1'b0;
  int            checks      = 0;
  int            failures    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check 1 time unit later, update the model at posedge.
  task automatic cycle(input bit st, input bit sl, input bit fl, input bit iv,
                       input logic [DW-1:0] id, input bit ordy);
    bit run;
    bit e_ir;
    bit e_ov;
    @(negedge clk);
    start_i      = st;
    stall_i      = sl;
    flush_i      = fl;
    in_if.valid  = iv;
    in_if.data   = id;
    out_if.ready = ordy;
    #1;
    run  = st && !fl && !sl;
    e_ir = run && (mq.size() < CAP);
    e_ov = run && (mq.size() > 0);
    check_eq("in_ready", in_if.ready, e_ir);
    check_eq("out_valid", out_if.valid, e_ov);
    if (mq.size() > 0) check_eq("out_data", out_if.data, mq[0]);
    check_eq("start_o", start_o, exp_start_o);
`ifdef PIPE_PERF_CNT_EN
    check_eq("stall_cnt", stall_cnt, n_stall);
    check_eq("flush_cnt", flush_cnt, n_flush);
`endif
    @(posedge clk);
    exp_start_o = st;
`ifdef PIPE_PERF_CNT_EN
    if (st && sl) n_stall++;
    if (st && fl) n_flush++;
`endif
    if (st && fl) begin
      mq.delete();
    end else if (run) begin
      if (e_ov && ordy) void'(mq.pop_front());
      if (iv && e_ir) mq.push_back(id);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_eq("rst_out_valid", out_if.valid, 1'b0);
    check_eq("rst_out_data", out_if.data, '0);
    check_eq("rst_in_ready", in_if.ready, 1'b0);
    check_eq("rst_start_o", start_o, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 0);
    check_eq("rst_flush_cnt", flush_cnt, 0);
    n_stall = 0;
    n_flush = 0;
`endif
    mq.delete();
    exp_start_o  = 1'b0;
    start_i      = 1'b0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    apply_reset();

    // Streaming 0x1..0x8 back-to-back, downstream always ready.
    for (int i = 1; i <= 8; i++) cycle(1, 0, 0, 1, DW'(i), 1);
    cycle(1, 0, 0, 0, '0, 1);
    cycle(1, 0, 0, 0, '0, 1);

    // Back-pressure: 0xA held, 0xB into skid, then drain in order.
    cycle(1, 0, 0, 1, 64'hA, 0);
    cycle(1, 0, 0, 1, 64'hB, 0);
    cycle(1, 0, 0, 1, 64'hEE, 0);
    cycle(1, 0, 0, 0, '0, 1);
    cycle(1, 0, 0, 0, '0, 1);
    cycle(1, 0, 0, 0, '0, 1);

    // Flush with both entries full and a same-cycle input.
    cycle(1, 0, 0, 1, 64'hA, 0);
    cycle(1, 0, 0, 1, 64'hB, 0);
    cycle(1, 0, 1, 1, 64'hC, 1);
    #2;
    check_eq("flush_data_zero", out_if.data, '0);
    cycle(1, 0, 0, 0, '0, 1);

    // Stall holds 0x5, released once; then stall+flush together.
    cycle(1, 0, 0, 1, 64'h5, 0);
    cycle(1, 1, 0, 0, '0, 1);
    cycle(1, 1, 0, 0, '0, 1);
    cycle(1, 0, 0, 0, '0, 1);
    cycle(1, 0, 0, 0, '0, 1);
    cycle(1, 0, 0, 1, 64'h6, 0);
    cycle(1, 1, 1, 1, 64'h7, 1);
    cycle(1, 0, 0, 0, '0, 1);

    // Freeze: nothing accepted, start_o drops.
    cycle(0, 0, 0, 1, 64'h9, 1);
    cycle(0, 0, 0, 1, 64'h9, 1);
    cycle(1, 0, 0, 0, '0, 1);

    // Async reset mid-stream with out_valid high.
    cycle(1, 0, 0, 1, 64'h11, 0);
    cycle(1, 0, 0, 1, 64'h12, 0);
    apply_reset();

    // 3 stall cycles and 1 flush cycle after reset.
    cycle(1, 1, 0, 0, '0, 1);
    cycle(1, 1, 0, 0, '0, 1);
    cycle(1, 1, 0, 0, '0, 1);
    cycle(1, 0, 1, 0, '0, 1);
    #2;
`ifdef PIPE_PERF_CNT_EN
    check_eq("stall_cnt_3", stall_cnt, 3);
    check_eq("flush_cnt_1", flush_cnt, 1);
`endif

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
